collision_scanner: RTL and testbench
====================================

# collision_scanner

Frame-synchronous collision engine generalising the single bullet/alien detector to N_BULLETS projectiles against an N_ALIENS formation. On each `fsync` it snapshots all bounding boxes and serially tests one (bullet, alien) pair per `pixel_clk`, then publishes per-alien kill, per-bullet consume and hit-count results as one registered set. It sits between the sprite/position logic and the game-state controller, which clears aliens and retires bullets from its outputs.

## Interface
- N_BULLETS, 2: number of bullet channels (1..8)
- N_ALIENS, 8: number of alien slots (1..32)
- COORD_W, 12: signed coordinate width
- pixel_clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- fsync  in  1  frame-start strobe; starts a scan when idle
- bullet_active  in  N_BULLETS  per-bullet valid
- bullet_box  in  N_BULLETS*4*COORD_W  box i at [i*4*COORD_W +: 4*COORD_W], fields {left,right,top,bottom}, left in MSBs, signed
- alien_alive  in  N_ALIENS  per-alien valid
- alien_box  in  N_ALIENS*4*COORD_W  same packing as bullet_box
- alien_hit  out  N_ALIENS  aliens killed in last completed scan
- bullet_hit  out  N_BULLETS  bullets consumed in last completed scan
- hit_count  out  $clog2(N_ALIENS+1)  popcount of alien_hit
- hit_valid  out  1  one-cycle pulse: result set updated
- busy  out  1  high in SCAN and DONE
- overrun  out  1  sticky: fsync arrived while busy

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE: on `fsync`, snapshot bullet_active, bullet_box, alien_alive and alien_box into internal registers, clear working vectors, set b_idx=0, a_idx=0, go to SCAN.
- SCAN: evaluate pair (b_idx, a_idx) from the snapshot only. Hit when bullet active, alien alive, alien not yet in working alien vector, bullet not yet in working bullet vector, and overlap holds: b.right >= a.left, b.left <= a.right, b.bottom >= a.top, b.top <= a.bottom. All comparisons are signed and inclusive, so touching edges count.
- On hit: set work_alien[a_idx], work_bullet[b_idx], increment work_count.
- Iteration: a_idx increments fastest. At a_idx=N_ALIENS-1 it wraps to 0 and b_idx increments. After pair (N_BULLETS-1, N_ALIENS-1) the FSM goes to DONE.
- Priority result: each bullet kills at most the lowest-index overlapping live alien. Each alien is killed by at most the lowest-index bullet. A consumed bullet is skipped for remaining aliens.
- DONE: copy working vectors and count to outputs, pulse hit_valid, return to IDLE.
- Outputs hold their values until the next DONE.
- `fsync` while busy: ignored (no restart, snapshot untouched). Sets `overrun`. `overrun` clears only on rst.
- Input changes during SCAN have no effect.

## Timing
- Reset values: alien_hit=0, bullet_hit=0, hit_count=0, hit_valid=0, busy=0, overrun=0. FSM returns to IDLE.
- rst mid-scan aborts the scan. No hit_valid is issued and the snapshot is discarded.
- Counting the fsync cycle as cycle 0:
  - SCAN occupies cycles 1..P, where P=N_BULLETS*N_ALIENS.
  - DONE occupies cycle P+1.
  - Outputs and hit_valid are visible in cycle P+2.
- busy is high in cycles 1..P+1.
- An fsync in cycle P+2 or later starts a new scan.
- Frame period must exceed P+2 cycles. Violations are flagged by overrun, never silently merged.
- fsync coincident with rst: rst wins.

## Structure
- Package `collision_pkg`:
  - COORD_W_DEFAULT=12.
  - `box_t` packed struct {left,right,top,bottom}.
  - `scan_state_t` enum {IDLE,SCAN,DONE}.
  - function `unpack_box`.
- Sub-module `box_overlap`: purely combinational, two box_t in, 1-bit overlap out, inclusive signed compare. Instantiated once on the muxed pair.
- Top holds the snapshot registers, index counters, FSM and working and output registers.

## Test plan
Use N_BULLETS=2, N_ALIENS=4 (P=8).
- Single hit: bullet0 {10,12,50,58} active; alien2 {8,24,40,56} alive; fsync → cycle 10: hit_valid=1, alien_hit=4'b0100, bullet_hit=2'b01, hit_count=1.
- Edge touch and priority: bullet0 right=20 touches alien0 left=20 and also overlaps alien1 → alien_hit=4'b0001, bullet_hit=2'b01.
- Shared target: both bullets overlap alien3 only → alien_hit=4'b1000, bullet_hit=2'b01, hit_count=1.
- Masking and signed coordinates: alien1 overlaps bullet1 but alien_alive[1]=0 → alien_hit=0. Bullet box {-5,-1,...} overlapping alien {-3,4,...} → hit.
- Snapshot and overrun: change boxes and pulse fsync at cycle 4 → result reflects cycle-0 snapshot, overrun=1, only one hit_valid.
- Reset mid-scan: rst at cycle 5 → all outputs 0, no hit_valid. A fresh fsync afterwards yields a correct result at fsync+10.

Source files
------------

// File: rtl/collision_scanner_pkg.sv
// Shared types for the collision scanner: box layout, scan FSM states and the
// helper that slices a packed coordinate word into a box.
package collision_pkg;

  localparam int COORD_W_DEFAULT = 12;

  typedef struct packed {
    logic signed [COORD_W_DEFAULT-1:0] left;
    logic signed [COORD_W_DEFAULT-1:0] right;
    logic signed [COORD_W_DEFAULT-1:0] top;
    logic signed [COORD_W_DEFAULT-1:0] bottom;
  } box_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  // Field order follows the bus packing: left occupies the MSBs.
  function automatic box_t unpack_box(input logic [4*COORD_W_DEFAULT-1:0] v);
    box_t b;
    b.left   = v[4*COORD_W_DEFAULT-1 -: COORD_W_DEFAULT];
    b.right  = v[3*COORD_W_DEFAULT-1 -: COORD_W_DEFAULT];
    b.top    = v[2*COORD_W_DEFAULT-1 -: COORD_W_DEFAULT];
    b.bottom = v[1*COORD_W_DEFAULT-1 -: COORD_W_DEFAULT];
    return b;
  endfunction

endpackage

// File: rtl/collision_scanner_if.sv
// Bus between the sprite/position logic, the collision scanner and the
// game-state controller. The scanner takes the slave side.
interface collision_scanner_if #(
  parameter int N_BULLETS = 2,
  parameter int N_ALIENS  = 8,
  parameter int COORD_W   = 12
);
  localparam int CNT_W = $clog2(N_ALIENS + 1);

  logic                            fsync;
  logic [N_BULLETS-1:0]            bullet_active;
  logic [N_BULLETS*4*COORD_W-1:0]  bullet_box;
  logic [N_ALIENS-1:0]             alien_alive;
  logic [N_ALIENS*4*COORD_W-1:0]   alien_box;
  logic [N_ALIENS-1:0]             alien_hit;
  logic [N_BULLETS-1:0]            bullet_hit;
  logic [CNT_W-1:0]                hit_count;
  logic                            hit_valid;
  logic                            busy;
  logic                            overrun;

  modport master (
    output fsync, bullet_active, bullet_box, alien_alive, alien_box,
    input  alien_hit, bullet_hit, hit_count, hit_valid, busy, overrun
  );

  modport slave (
    input  fsync, bullet_active, bullet_box, alien_alive, alien_box,
    output alien_hit, bullet_hit, hit_count, hit_valid, busy, overrun
  );

endinterface

// File: rtl/collision_scanner_box_overlap.sv
// Inclusive signed rectangle overlap test; edges that merely touch count as
// a collision.
module box_overlap
  import collision_pkg::*;
(
  input  box_t bullet,
  input  box_t alien,
  output logic overlap
);

  assign overlap = ($signed(bullet.right)  >= $signed(alien.left))  &&
                   ($signed(bullet.left)   <= $signed(alien.right)) &&
                   ($signed(bullet.bottom) >= $signed(alien.top))   &&
                   ($signed(bullet.top)    <= $signed(alien.bottom));

endmodule

// File: rtl/collision_scanner.sv
// Frame-synchronous collision engine: snapshots all boxes on fsync, walks every
// (bullet, alien) pair one per clock, then publishes the result set at once.
module collision_scanner
  import collision_pkg::*;
#(
  parameter int N_BULLETS = 2,
  parameter int N_ALIENS  = 8,
  parameter int COORD_W   = COORD_W_DEFAULT
) (
  input logic pixel_clk,
  input logic rst,
  collision_scanner_if.slave bus
);

  localparam int BOX_W = 4 * COORD_W;
  localparam int BW    = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1;
  localparam int AW    = (N_ALIENS > 1) ? $clog2(N_ALIENS) : 1;
  localparam int CW    = $clog2(N_ALIENS + 1);
  localparam logic [BW-1:0] B_LAST = BW'(N_BULLETS - 1);
  localparam logic [AW-1:0] A_LAST = AW'(N_ALIENS - 1);

  scan_state_t                   state_q, state_d;
  logic [BW-1:0]                 b_idx_q, b_idx_d;
  logic [AW-1:0]                 a_idx_q, a_idx_d;
  logic [N_BULLETS-1:0]          snap_bact_q, snap_bact_d;
  logic [N_BULLETS*BOX_W-1:0]    snap_bbox_q, snap_bbox_d;
  logic [N_ALIENS-1:0]           snap_alive_q, snap_alive_d;
  logic [N_ALIENS*BOX_W-1:0]     snap_abox_q, snap_abox_d;
  logic [N_ALIENS-1:0]           work_alien_q, work_alien_d;
  logic [N_BULLETS-1:0]          work_bullet_q, work_bullet_d;
  logic [CW-1:0]                 work_count_q, work_count_d;
  logic [N_ALIENS-1:0]           alien_hit_q, alien_hit_d;
  logic [N_BULLETS-1:0]          bullet_hit_q, bullet_hit_d;
  logic [CW-1:0]                 hit_count_q, hit_count_d;
  logic                          hit_valid_q, hit_valid_d;
  logic                          busy_q, busy_d;
  logic                          overrun_q, overrun_d;

  box_t bullet_s, alien_s;
  logic overlap_s, hit_s;

  assign bullet_s = unpack_box(snap_bbox_q[b_idx_q*BOX_W +: BOX_W]);
  assign alien_s  = unpack_box(snap_abox_q[a_idx_q*BOX_W +: BOX_W]);

  box_overlap u_overlap (
    .bullet  (bullet_s),
    .alien   (alien_s),
    .overlap (overlap_s)
  );

  // Already-claimed aliens and consumed bullets are masked, giving lowest-index priority.
  assign hit_s = snap_bact_q[b_idx_q] & snap_alive_q[a_idx_q] &
                 ~work_alien_q[a_idx_q] & ~work_bullet_q[b_idx_q] & overlap_s;

  always_comb begin
    state_d       = state_q;
    b_idx_d       = b_idx_q;
    a_idx_d       = a_idx_q;
    snap_bact_d   = snap_bact_q;
    snap_bbox_d   = snap_bbox_q;
    snap_alive_d  = snap_alive_q;
    snap_abox_d   = snap_abox_q;
    work_alien_d  = work_alien_q;
    work_bullet_d = work_bullet_q;
    work_count_d  = work_count_q;
    alien_hit_d   = alien_hit_q;
    bullet_hit_d  = bullet_hit_q;
    hit_count_d   = hit_count_q;
    hit_valid_d   = 1'b0;
    overrun_d     = overrun_q | (bus.fsync & busy_q);

    case (state_q)
      IDLE: begin
        if (bus.fsync) begin
          snap_bact_d   = bus.bullet_active;
          snap_bbox_d   = bus.bullet_box;
          snap_alive_d  = bus.alien_alive;
          snap_abox_d   = bus.alien_box;
          work_alien_d  = '0;
          work_bullet_d = '0;
          work_count_d  = '0;
          b_idx_d       = '0;
          a_idx_d       = '0;
          state_d       = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (hit_s) begin
          work_alien_d[a_idx_q]  = 1'b1;
          work_bullet_d[b_idx_q] = 1'b1;
          work_count_d           = work_count_q + CW'(1);
        end else begin
          work_count_d = work_count_q;
        end
        if (a_idx_q == A_LAST) begin
          a_idx_d = '0;
          if (b_idx_q == B_LAST) begin
            state_d = DONE;
          end else begin
            b_idx_d = b_idx_q + BW'(1);
          end
        end else begin
          a_idx_d = a_idx_q + AW'(1);
        end
      end
      DONE: begin
        alien_hit_d  = work_alien_q;
        bullet_hit_d = work_bullet_q;
        hit_count_d  = work_count_q;
        hit_valid_d  = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q       <= IDLE;
      b_idx_q       <= '0;
      a_idx_q       <= '0;
      snap_bact_q   <= '0;
      snap_bbox_q   <= '0;
      snap_alive_q  <= '0;
      snap_abox_q   <= '0;
      work_alien_q  <= '0;
      work_bullet_q <= '0;
      work_count_q  <= '0;
      alien_hit_q   <= '0;
      bullet_hit_q  <= '0;
      hit_count_q   <= '0;
      hit_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      b_idx_q       <= b_idx_d;
      a_idx_q       <= a_idx_d;
      snap_bact_q   <= snap_bact_d;
      snap_bbox_q   <= snap_bbox_d;
      snap_alive_q  <= snap_alive_d;
      snap_abox_q   <= snap_abox_d;
      work_alien_q  <= work_alien_d;
      work_bullet_q <= work_bullet_d;
      work_count_q  <= work_count_d;
      alien_hit_q   <= alien_hit_d;
      bullet_hit_q  <= bullet_hit_d;
      hit_count_q   <= hit_count_d;
      hit_valid_q   <= hit_valid_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.alien_hit  = alien_hit_q;
  assign bus.bullet_hit = bullet_hit_q;
  assign bus.hit_count  = hit_count_q;
  assign bus.hit_valid  = hit_valid_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_collision_scanner.sv
// Directed bench for collision_scanner (2 bullets, 4 aliens): a frame-level
// reference model checked every cycle, plus hand-computed per-scenario results.
module tb_collision_scanner;

  localparam int NB = 2;
  localparam int NA = 4;
  localparam int W  = 12;
  localparam int P  = NB * NA;

  logic pixel_clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  collision_scanner_if #(.N_BULLETS(NB), .N_ALIENS(NA), .COORD_W(W)) bus ();

  collision_scanner #(.N_BULLETS(NB), .N_ALIENS(NA), .COORD_W(W)) dut (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .bus       (bus)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4*W-1:0] bx(input int l, input int r, input int t, input int b);
    return {W'(l), W'(r), W'(t), W'(b)};
  endfunction

  function automatic int fld(input logic [4*W-1:0] v, input int k);
    logic signed [W-1:0] f;
    f = v[(4-k)*W-1 -: W];
    return int'(f);
  endfunction

  // Reference model: each bullet in turn claims the lowest free overlapping live alien
  logic [NA-1:0] exp_ah = '0, pend_ah;
  logic [NB-1:0] exp_bh = '0, pend_bh;
  int            exp_cnt = 0, pend_cnt;
  bit            exp_hv = 1'b0, exp_busy = 1'b0, exp_ov = 1'b0;
  int            m_left = 0;

  always @(posedge pixel_clk) begin
    logic [4*W-1:0] bb, ab;
    bit was_busy;
    if (rst) begin
      exp_ah = '0; exp_bh = '0; exp_cnt = 0;
      exp_hv = 1'b0; exp_busy = 1'b0; exp_ov = 1'b0; m_left = 0;
    end else begin
      exp_hv = 1'b0;
      was_busy = (m_left > 0);
      if (was_busy) begin
        m_left--;
        if (m_left == 0) begin
          exp_ah = pend_ah; exp_bh = pend_bh; exp_cnt = pend_cnt; exp_hv = 1'b1;
        end
      end
      if (bus.fsync) begin
        if (was_busy) begin
          exp_ov = 1'b1;
        end else begin
          pend_ah = '0; pend_bh = '0; pend_cnt = 0;
          for (int b = 0; b < NB; b++) begin
            if (!bus.bullet_active[b]) continue;
            bb = bus.bullet_box[b*4*W +: 4*W];
            for (int a = 0; a < NA; a++) begin
              ab = bus.alien_box[a*4*W +: 4*W];
              if (bus.alien_alive[a] && !pend_ah[a] &&
                  fld(bb,1) >= fld(ab,0) && fld(bb,0) <= fld(ab,1) &&
                  fld(bb,3) >= fld(ab,2) && fld(bb,2) <= fld(ab,3)) begin
                pend_ah[a] = 1'b1; pend_bh[b] = 1'b1; pend_cnt++;
                break;
              end
            end
          end
          m_left = P + 1;
        end
      end
      exp_busy = (m_left > 0);
    end
  end

  always @(negedge pixel_clk) begin
    if (chk_en) begin
      check("model_alien_hit", 32'(bus.alien_hit), 32'(exp_ah));
      check("model_bullet_hit", 32'(bus.bullet_hit), 32'(exp_bh));
      check("model_hit_count", 32'(bus.hit_count), 32'(exp_cnt));
      check("model_hit_valid", 32'(bus.hit_valid), 32'(exp_hv));
      check("model_busy", 32'(bus.busy), 32'(exp_busy));
      check("model_overrun", 32'(bus.overrun), 32'(exp_ov));
    end
  end

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.bullet_active = '0;
    bus.alien_alive   = '0;
    bus.bullet_box    = '0;
    bus.alien_box     = '0;
  endtask

  task automatic set_bullet(input int i, input logic [4*W-1:0] v);
    bus.bullet_active[i] = 1'b1;
    bus.bullet_box[i*4*W +: 4*W] = v;
  endtask

  task automatic set_alien(input int i, input bit alive, input logic [4*W-1:0] v);
    bus.alien_alive[i] = alive;
    bus.alien_box[i*4*W +: 4*W] = v;
  endtask

  // Pulses fsync (cycle 0), advances to cycle P+2 and checks the published set.
  task automatic frame(input string name, input logic [NA-1:0] ah, input logic [NB-1:0] bh, input int cnt);
    bus.fsync = 1'b1;
    tick();
    bus.fsync = 1'b0;
    repeat (P + 1) tick();
    check({name, "_hit_valid"}, 32'(bus.hit_valid), 32'd1);
    check({name, "_alien_hit"}, 32'(bus.alien_hit), 32'(ah));
    check({name, "_bullet_hit"}, 32'(bus.bullet_hit), 32'(bh));
    check({name, "_hit_count"}, 32'(bus.hit_count), 32'(cnt));
    tick();
    check({name, "_pulse_end"}, 32'(bus.hit_valid), 32'd0);
  endtask

  task automatic setup_single();
    clear_inputs();
    set_bullet(0, bx(10, 12, 50, 58));
    set_alien(2, 1'b1, bx(8, 24, 40, 56));
  endtask

  initial begin
    int hv;
    bus.fsync = 1'b0;
    clear_inputs();
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_alien_hit", 32'(bus.alien_hit), 32'd0);
    check("reset_hit_valid", 32'(bus.hit_valid), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_overrun", 32'(bus.overrun), 32'd0);

    setup_single();
    frame("single", 4'b0100, 2'b01, 1);

    clear_inputs();
    set_bullet(0, bx(15, 20, 0, 10));
    set_alien(0, 1'b1, bx(20, 30, 0, 10));
    set_alien(1, 1'b1, bx(18, 25, 5, 8));
    frame("edge_prio", 4'b0001, 2'b01, 1);

    clear_inputs();
    set_bullet(0, bx(105, 110, 105, 110));
    set_bullet(1, bx(110, 115, 110, 115));
    set_alien(0, 1'b1, bx(500, 510, 500, 510));
    set_alien(1, 1'b1, bx(600, 610, 600, 610));
    set_alien(2, 1'b1, bx(700, 710, 700, 710));
    set_alien(3, 1'b1, bx(100, 120, 100, 120));
    frame("shared", 4'b1000, 2'b01, 1);

    clear_inputs();
    set_bullet(0, bx(-5, -1, -5, -1));
    set_alien(0, 1'b1, bx(-3, 4, -3, 4));
    set_bullet(1, bx(200, 210, 200, 210));
    set_alien(1, 1'b0, bx(205, 215, 205, 215));
    frame("mask_signed", 4'b0001, 2'b01, 1);

    clear_inputs();
    set_bullet(0, bx(6, 8, 2, 4));
    set_bullet(1, bx(6, 8, 2, 4));
    set_alien(0, 1'b1, bx(0, 10, 0, 10));
    set_alien(1, 1'b1, bx(5, 15, 0, 10));
    set_alien(2, 1'b1, bx(1000, 1010, 1000, 1010));
    set_alien(3, 1'b1, bx(-1000, -990, 0, 10));
    frame("two_hits", 4'b0011, 2'b11, 2);

    // Snapshot isolation and overrun: disturb inputs and re-pulse fsync at cycle 4.
    setup_single();
    bus.fsync = 1'b1;
    tick();
    bus.fsync = 1'b0;
    repeat (3) tick();
    bus.bullet_active = '0;
    set_alien(2, 1'b1, bx(900, 910, 900, 910));
    bus.fsync = 1'b1;
    tick();
    bus.fsync = 1'b0;
    hv = 0;
    for (int c = 5; c <= 20; c++) begin
      if (c == P + 2) begin
        check("snap_alien_hit", 32'(bus.alien_hit), 32'b0100);
        check("snap_bullet_hit", 32'(bus.bullet_hit), 32'b01);
      end
      hv += int'(bus.hit_valid);
      tick();
    end
    check("snap_one_pulse", 32'(hv), 32'd1);
    check("snap_overrun", 32'(bus.overrun), 32'd1);

    // Reset in cycle 5 of a scan: everything clears and no result is published.
    clear_inputs();
    set_bullet(1, bx(0, 3, 0, 3));
    set_alien(3, 1'b1, bx(3, 9, 3, 9));
    bus.fsync = 1'b1;
    tick();
    bus.fsync = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_alien_hit", 32'(bus.alien_hit), 32'd0);
    check("rst_bullet_hit", 32'(bus.bullet_hit), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    hv = 0;
    for (int c = 0; c < 12; c++) begin
      hv += int'(bus.hit_valid);
      tick();
    end
    check("rst_no_pulse", 32'(hv), 32'd0);
    frame("after_rst", 4'b1000, 2'b10, 1);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
